hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and branch-redirect controller for the 5-stage core. Decides every cycle whether IF/ID advance, stall or flush and whether the PC takes PC+4 or a resolved branch target, such as a taken `bne` resolved in EX. Sits beside the pipeline registers and drives their write/flush enables. Handles multi-cycle load-use stalls with an internal counter and a global freeze while data memory is busy.

## Interface
- `LOAD_LAT`, 1, load-use stall length in cycles, legal 1..7
- `clk`  in  1  core clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID
- `id_use_rs1`, `id_use_rs2`  in  1 each  ID instruction reads rs1 / rs2
- `ex_rd`  in  5  destination of the instruction in EX
- `ex_mem_read`  in  1  EX instruction is a load
- `ex_branch`  in  1  EX instruction is a conditional branch
- `ex_taken`  in  1  branch condition true, valid with `ex_branch`
- `ex_target`  in  32  branch target, valid with `ex_branch`
- `mem_busy`  in  1  data memory not ready, freeze pipeline
- `pc_write`  out  1  PC register load enable
- `pc_sel`  out  1  0 = PC+4, 1 = `pc_target`
- `pc_target`  out  32  redirect address, equals `ex_target`
- `if_id_write`  out  1  IF/ID load enable
- `if_id_flush`  out  1  IF/ID loads a NOP
- `id_ex_write`  out  1  ID/EX load enable; when 0 the later stages also hold
- `id_ex_bubble`  out  1  ID/EX loads a NOP
- `state`  out  2  RUN=0, STALL=1, FLUSH=2
- `stall_cnt`, `flush_cnt`  out  16 each  performance counters (see Configuration)

## Operation
- `load_use` = `ex_mem_read` & `ex_rd`!=0 & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)).
- `redirect` = `ex_branch` & `ex_taken`.
- Priority, highest first: `rst` > `mem_busy` > `redirect` > STALL state / `load_use` > normal.
- `rst` high: state=RUN, counter=0, perf counters=0; outputs `pc_write`=0, `if_id_write`=0, `id_ex_write`=1, `id_ex_bubble`=1, `if_id_flush`=1, `pc_sel`=0.
- `mem_busy`: `pc_write`=`if_id_write`=`id_ex_write`=0, `id_ex_bubble`=`if_id_flush`=0; state, counter and perf counters hold.
- `redirect` in any state: `pc_write`=1, `pc_sel`=1, `if_id_flush`=1, `id_ex_bubble`=1; next state FLUSH, counter cleared.
- RUN & `load_use`: `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1. Next state is STALL with counter=`LOAD_LAT`-1 if `LOAD_LAT`>1, otherwise RUN.
- STALL: same outputs as the load-use stall; `load_use` input is ignored. The counter decrements each unfrozen cycle, and state returns to RUN when the counter steps from 1 to 0.
- FLUSH: lasts one cycle. Outputs are normal and `load_use` and `ex_branch` are ignored, because ID and EX hold bubbles. Next state is RUN.
- Normal: `pc_write`=`if_id_write`=`id_ex_write`=1, `pc_sel`=0, flush and bubble signals 0.
- `pc_target` always equals `ex_target`.
- `ex_rd`=0 never causes a stall.

## Timing
- Control outputs are combinational from state, counter and inputs in the same cycle; only state and counters are registered.
- Taken branch costs 2 slots: the IF/ID and ID/EX contents at the redirect edge are squashed, and the target is fetched in the next cycle.
- Load-use costs exactly `LOAD_LAT` cycles, counting only cycles with `mem_busy`=0.
- `rst` asserted mid-stall takes effect immediately and asynchronously; the first cycle after release is RUN with normal outputs.
- Redirect on the last STALL cycle goes to FLUSH, not RUN.

## Configuration
- `HAZ_PERF_CNT_EN` defined:
  - `stall_cnt` counts cycles with state STALL or a RUN load-use stall, excluding `mem_busy` cycles.
  - `flush_cnt` counts redirect events.
  - Both counters are 16-bit, saturate at 0xFFFF and reset to 0.
- Not defined: both ports are tied to 0 and no counter flops exist.

## Test plan
- Taken branch: RUN, `ex_branch`=1, `ex_taken`=1, `ex_target`=0x0000008C. Same cycle: `pc_sel`=1, `pc_target`=0x8C, `if_id_flush`=`id_ex_bubble`=1. Next cycle: `state`=2, then `state`=0; `flush_cnt`=1.
- Not-taken branch: `ex_branch`=1, `ex_taken`=0 → `pc_sel`=0, no flush, state stays 0.
- Load-use with `LOAD_LAT`=3: `ex_mem_read`=1, `ex_rd`=10, `id_rs2`=10, `id_use_rs2`=1 → `pc_write`=0 for exactly 3 cycles, then `state`=0; `stall_cnt`=3.
- Freeze mid-stall with `LOAD_LAT`=3: `mem_busy`=1 for 2 cycles during STALL → all write enables 0 and the counter holds; total `pc_write`=0 span is 5 cycles.
- Priority: load-use and taken branch in the same cycle → redirect outputs only, `state`=2. With `ex_rd`=0 and a matching rs → no stall.
- Async reset: `rst` pulsed mid-STALL between clock edges → `state`=0 and `if_id_flush`=1 immediately; `stall_cnt` and `flush_cnt` are 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: groups the pipeline status inputs seen by the
// controller and the enables/redirect it drives back into the pipeline.
// The controller side uses modport "slave"; the pipeline/bench side uses
// modport "master".
interface hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_branch;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        mem_busy;

  logic        pc_write;
  logic        pc_sel;
  logic [31:0] pc_target;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_write;
  logic        id_ex_bubble;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch, ex_taken, ex_target, mem_busy,
    input  pc_write, pc_sel, pc_target, if_id_write, if_id_flush,
           id_ex_write, id_ex_bubble, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch, ex_taken, ex_target, mem_busy,
    output pc_write, pc_sel, pc_target, if_id_write, if_id_flush,
           id_ex_write, id_ex_bubble, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and branch-redirect controller for the
// 5-stage core. Drives PC / IF/ID / ID/EX enables, inserts load-use stalls
// of LOAD_LAT cycles, squashes the two younger slots on a taken branch and
// freezes everything while data memory is busy.
// Optional feature macro: HAZ_PERF_CNT_EN enables the 16-bit saturating
// stall_cnt / flush_cnt performance counters; without it both read as 0.
module hazard_ctrl #(
  parameter int LOAD_LAT = 1
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [2:0] STALL_INIT = 3'(LOAD_LAT - 1);

  state_t     state_q;
  state_t     state_d;
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  logic load_use;
  logic redirect;
  logic redirect_eff;
  logic stall_inc;
  logic flush_inc;

  // Hazard detection; FLUSH ignores the EX branch because EX holds a bubble
  always_comb begin
    load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
               ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
    redirect     = bus.ex_branch && bus.ex_taken;
    redirect_eff = redirect && (state_q != FLUSH);
  end

  // State and stall-length counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and pipeline control outputs, priority reset > freeze > redirect > stall
  always_comb begin
    bus.pc_write     = 1'b1;
    bus.pc_sel       = 1'b0;
    bus.if_id_write  = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_write  = 1'b1;
    bus.id_ex_bubble = 1'b0;
    state_d          = state_q;
    cnt_d            = cnt_q;
    stall_inc        = 1'b0;
    flush_inc        = 1'b0;

    if (rst) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_bubble = 1'b1;
      state_d          = RUN;
      cnt_d            = 3'd0;
    end else if (bus.mem_busy) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.id_ex_write  = 1'b0;
    end else if (redirect_eff) begin
      bus.pc_sel       = 1'b1;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_bubble = 1'b1;
      state_d          = FLUSH;
      cnt_d            = 3'd0;
      flush_inc        = 1'b1;
      stall_inc        = (state_q == STALL);
    end else begin
      case (state_q)
        RUN: begin
          if (load_use) begin
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.id_ex_bubble = 1'b1;
            stall_inc        = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = STALL;
              cnt_d   = STALL_INIT;
            end
          end
        end
        STALL: begin
          bus.pc_write     = 1'b0;
          bus.if_id_write  = 1'b0;
          bus.id_ex_bubble = 1'b1;
          stall_inc        = 1'b1;
          if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        FLUSH: begin
          state_d = RUN;
        end
        default: begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // Redirect address is a straight pass-through of the EX target
  always_comb begin
    bus.pc_target = bus.ex_target;
    bus.state     = state_q;
  end

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Saturating performance counters, frozen while memory is busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stall_inc && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (flush_inc && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  // Expose the counters
  always_comb begin
    bus.stall_cnt = stall_cnt_q;
    bus.flush_cnt = flush_cnt_q;
  end
`else
  logic unused_perf;

  // Counters absent: ports read as zero
  always_comb begin
    bus.stall_cnt = 16'd0;
    bus.flush_cnt = 16'd0;
    unused_perf   = stall_inc ^ flush_inc;
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl with LOAD_LAT=3. Single-cycle control vectors
// come from a table; multi-cycle corners (branch flush, load-use stall,
// freeze mid-stall, async reset, redirect on last stall cycle) are
// hand-written sequences.
module tb_hazard_ctrl;

  localparam int LAT = 3;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_write, pc_sel, if_id_write, if_id_flush, id_ex_write, id_ex_bubble}
  localparam logic [5:0] C_NORM  = 6'b101010;
  localparam logic [5:0] C_REDIR = 6'b111111;
  localparam logic [5:0] C_STALL = 6'b000011;
  localparam logic [5:0] C_BUSY  = 6'b000000;
  localparam logic [5:0] C_RST   = 6'b000111;

  typedef struct {
    string       name;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use1;
    logic        use2;
    logic [4:0]  rd;
    logic        mread;
    logic        br;
    logic        tk;
    logic [31:0] tgt;
    logic        busy;
    logic [5:0]  exp_ctl;
    logic [1:0]  exp_state;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t vecs[11];
  vec_t idle;

  hazard_ctrl_if bus();

  hazard_ctrl #(.LOAD_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10-unit clock, rising edges at 5, 15, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a sequence never returns
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(string name, logic [4:0] rs1, logic [4:0] rs2,
                              logic use1, logic use2, logic [4:0] rd,
                              logic mread, logic br, logic tk,
                              logic [31:0] tgt, logic busy,
                              logic [5:0] ctl, logic [1:0] st);
    vec_t v;
    v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2;
    v.rd = rd; v.mread = mread; v.br = br; v.tk = tk; v.tgt = tgt;
    v.busy = busy; v.exp_ctl = ctl; v.exp_state = st;
    return v;
  endfunction

  function automatic logic [5:0] ctl();
    return {bus.pc_write, bus.pc_sel, bus.if_id_write, bus.if_id_flush,
            bus.id_ex_write, bus.id_ex_bubble};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.id_rs1      = v.rs1;
    bus.id_rs2      = v.rs2;
    bus.id_use_rs1  = v.use1;
    bus.id_use_rs2  = v.use2;
    bus.ex_rd       = v.rd;
    bus.ex_mem_read = v.mread;
    bus.ex_branch   = v.br;
    bus.ex_taken    = v.tk;
    bus.ex_target   = v.tgt;
    bus.mem_busy    = v.busy;
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(idle);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Load-use at cycle 0, optional freeze window; returns the pc_write=0 span
  task automatic runLoadUse(input int busy_from, input int busy_len,
                            output int span);
    vec_t v;
    span = 0;
    for (int i = 0; i < 16; i++) begin
      v = (i == 0) ? mk("lu", 5'd3, 5'd10, 1'b0, 1'b1, 5'd10, 1'b1, 1'b0,
                        1'b0, 32'h0, 1'b0, C_STALL, 2'd1) : idle;
      v.busy = (i >= busy_from) && (i < busy_from + busy_len);
      applyStimulus(v);
      if (v.busy) begin
        checkOutput("freeze_ctl", 32'(ctl()), 32'(C_BUSY));
        checkOutput("freeze_state", 32'(bus.state), 32'd1);
      end
      if (bus.pc_write) break;
      span++;
    end
    if (span >= 16) checkOutput("stall_bound", 32'(span), 32'd0);
  endtask

  initial begin
    int span;
    n_checks = 0;
    n_fail   = 0;
    idle = mk("idle", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
              32'h0, 1'b0, C_NORM, 2'd0);

    vecs[0]  = mk("idle", 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0,
                  32'h0, 1'b0, C_NORM, 2'd0);
    vecs[1]  = mk("br_not_taken", 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1,
                  1'b0, 32'h40, 1'b0, C_NORM, 2'd0);
    vecs[2]  = mk("br_taken", 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1,
                  32'h8C, 1'b0, C_REDIR, 2'd2);
    vecs[3]  = mk("lu_rs2", 5'd3, 5'd10, 1'b0, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0,
                  32'h0, 1'b0, C_STALL, 2'd1);
    vecs[4]  = mk("lu_rs1", 5'd7, 5'd9, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0,
                  32'h0, 1'b0, C_STALL, 2'd1);
    vecs[5]  = mk("rs1_unused", 5'd7, 5'd9, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0,
                  1'b0, 32'h0, 1'b0, C_NORM, 2'd0);
    vecs[6]  = mk("rd_zero", 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0,
                  32'h0, 1'b0, C_NORM, 2'd0);
    vecs[7]  = mk("not_load", 5'd4, 5'd4, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0,
                  32'h0, 1'b0, C_NORM, 2'd0);
    vecs[8]  = mk("lu_and_taken", 5'd3, 5'd10, 1'b0, 1'b1, 5'd10, 1'b1, 1'b1,
                  1'b1, 32'h1234, 1'b0, C_REDIR, 2'd2);
    vecs[9]  = mk("busy_taken", 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1,
                  1'b1, 32'hA0, 1'b1, C_BUSY, 2'd0);
    vecs[10] = mk("busy_lu", 5'd3, 5'd10, 1'b0, 1'b1, 5'd10, 1'b1, 1'b0,
                  1'b0, 32'h0, 1'b1, C_BUSY, 2'd0);

    // Reset values while reset is held
    rst = 1'b1;
    applyStimulus(idle);
    checkOutput("rst_ctl", 32'(ctl()), 32'(C_RST));
    checkOutput("rst_state", 32'(bus.state), 32'd0);
    checkOutput("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    checkOutput("rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven single-cycle vectors, each starting in RUN
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      checkOutput({vecs[i].name, "_ctl"}, 32'(ctl()), 32'(vecs[i].exp_ctl));
      checkOutput({vecs[i].name, "_target"}, bus.pc_target, vecs[i].tgt);
      @(posedge clk);
      #1;
      checkOutput({vecs[i].name, "_next"}, 32'(bus.state),
                  32'(vecs[i].exp_state));
      for (int k = 0; k < 4; k++) applyStimulus(idle);
    end

    // Taken branch: FLUSH for one cycle with normal outputs, then RUN
    $display("[TB] sequence: taken branch");
    doReset();
    applyStimulus(vecs[2]);
    checkOutput("tb_pc_sel", 32'(bus.pc_sel), 32'd1);
    checkOutput("tb_pc_target", bus.pc_target, 32'h8C);
    applyStimulus(vecs[8]);
    checkOutput("tb_flush_state", 32'(bus.state), 32'd2);
    checkOutput("tb_flush_ignores", 32'(ctl()), 32'(C_NORM));
    applyStimulus(idle);
    checkOutput("tb_back_run", 32'(bus.state), 32'd0);
    checkOutput("tb_flush_cnt", 32'(bus.flush_cnt), PERF ? 32'd1 : 32'd0);

    // Load-use: exactly LOAD_LAT stalled cycles
    $display("[TB] sequence: load-use");
    doReset();
    runLoadUse(99, 0, span);
    checkOutput("lu_span", 32'(span), 32'd3);
    checkOutput("lu_state", 32'(bus.state), 32'd0);
    checkOutput("lu_stall_cnt", 32'(bus.stall_cnt), PERF ? 32'd3 : 32'd0);

    // Freeze two cycles during STALL
    $display("[TB] sequence: freeze mid-stall");
    doReset();
    runLoadUse(1, 2, span);
    checkOutput("frz_span", 32'(span), 32'd5);
    checkOutput("frz_stall_cnt", 32'(bus.stall_cnt), PERF ? 32'd3 : 32'd0);

    // Async reset between edges while in STALL
    $display("[TB] sequence: async reset mid-stall");
    doReset();
    applyStimulus(vecs[3]);
    applyStimulus(idle);
    checkOutput("ar_in_stall", 32'(bus.state), 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("ar_state", 32'(bus.state), 32'd0);
    checkOutput("ar_flush", 32'(bus.if_id_flush), 32'd1);
    checkOutput("ar_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    checkOutput("ar_flush_cnt", 32'(bus.flush_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(idle);
    checkOutput("ar_after_ctl", 32'(ctl()), 32'(C_NORM));
    checkOutput("ar_after_state", 32'(bus.state), 32'd0);

    // Redirect on the last STALL cycle goes to FLUSH
    $display("[TB] sequence: redirect on last stall cycle");
    doReset();
    applyStimulus(vecs[3]);
    applyStimulus(idle);
    applyStimulus(vecs[2]);
    checkOutput("last_redir_ctl", 32'(ctl()), 32'(C_REDIR));
    applyStimulus(idle);
    checkOutput("last_redir_state", 32'(bus.state), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
